// File: rtl/sram_rw_port_ctrl.sv
// Request/response front end for port 0 of the sky130 32x512 OpenRAM macro.
// Optional power-up zero fill of the whole array: define SRAM_CTRL_SCRUB_EN.
module sram_rw_port_ctrl #(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int OUT_W = CNT_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCRUB = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  rd1_q, rd1_d;
    logic                  rd2_q;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef SRAM_CTRL_SCRUB_EN
    logic [ADDR_WIDTH-1:0] scrub_q, scrub_d;
`endif

    logic             accept;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] outstanding;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both read pipeline stages plus the FIFO. With two reads in
    // flight, sustained one-per-cycle reads need RSP_DEPTH >= 3.
    assign outstanding = OUT_W'(cnt_q) + OUT_W'(rd1_q) + OUT_W'(rd2_q);
    assign pop         = rsp_valid && rsp_ready;
    assign req_ready   = (state_q == ST_RUN) &&
                         (outstanding < OUT_W'(RSP_DEPTH) + OUT_W'(pop));
    assign accept      = req_valid && req_ready;
    assign push        = rd2_q;

    assign rsp_valid = (cnt_q != '0);
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign init_done = (state_q == ST_RUN);
    assign csb0      = csb0_q;
    assign web0      = web0_q;
    assign wmask0    = wmask0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;

    always_comb begin
        state_d  = state_q;
        csb0_d   = 1'b1;
        web0_d   = 1'b1;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        rd1_d    = 1'b0;
`ifdef SRAM_CTRL_SCRUB_EN
        scrub_d  = scrub_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_SCRUB: begin
`ifdef SRAM_CTRL_SCRUB_EN
                csb0_d   = 1'b0;
                web0_d   = 1'b0;
                wmask0_d = '1;
                addr0_d  = scrub_q;
                din0_d   = '0;
                scrub_d  = scrub_q + 1'b1;
                if (scrub_q == '1) state_d = ST_RUN;
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (accept) begin
                    csb0_d  = 1'b0;
                    web0_d  = ~req_we;
                    addr0_d = req_addr;
                    rd1_d   = ~req_we;
                    if (req_we) begin
                        wmask0_d = req_wmask;
                        din0_d   = req_wdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
`ifdef SRAM_CTRL_SCRUB_EN
            state_q <= ST_SCRUB;
            scrub_q <= '0;
`else
            state_q <= ST_IDLE;
`endif
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            rd1_q    <= 1'b0;
            rd2_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
`ifdef SRAM_CTRL_SCRUB_EN
            scrub_q  <= scrub_d;
`endif
            csb0_q   <= csb0_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
            rd1_q    <= rd1_d;
            // dout0 is valid after the macro's negedge update in the stage-2 cycle
            rd2_q    <= rd1_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) fifo_q[wr_ptr_q] <= dout0;
        end
    end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural model of the 1RW macro port.
module tb_sram_rw_port_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef SRAM_CTRL_SCRUB_EN
    localparam int INIT_CYC = 512;
`else
    localparam int INIT_CYC = 1;
`endif

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          req_valid, req_ready, req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          csb0, web0;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0, dout0;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk0 = ~clk0;

    sram_rw_port_ctrl dut (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0)
    );

    // Macro model: pins sampled at posedge, array write / dout0 update at the next negedge.
    logic [DW-1:0] mem [1 << AW];
    logic          s_en, s_we;
    logic [MW-1:0] s_mask;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;

    always @(posedge clk0) begin
        s_en   <= !csb0;
        s_we   <= !web0;
        s_mask <= wmask0;
        s_addr <= addr0;
        s_din  <= din0;
    end

    always @(negedge clk0) begin
        if (s_en) begin
            if (s_we) begin
                for (int b = 0; b < MW; b++)
                    if (s_mask[b]) mem[s_addr][b*8 +: 8] <= s_din[b*8 +: 8];
            end else begin
                dout0 <= mem[s_addr];
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: a response handshake completes at the posedge after this negedge.
    always @(negedge clk0) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%h required=none", rsp_rdata);
            end else begin
                check("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge, inputs still driven.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [MW-1:0] mask,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp, output int waits);
        logic acc;
        acc       = 1'b0;
        waits     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wmask = mask;
        req_wdata = wdata;
        while (!acc && waits <= 50) begin
            @(negedge clk0);
            acc = req_ready;
            @(posedge clk0);
            #1;
            if (!acc) waits++;
        end
        if (!acc) check("req_timeout", 0, 1);
        else if (!we) exp_q.push_back(exp);
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (!init_done && cyc < 2000) begin
            @(posedge clk0);
            #1;
            cyc++;
        end
        check("init_done", init_done, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        idle();
        while ((exp_q.size() != 0 || rsp_valid) && n < 40) begin
            @(posedge clk0);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int w, w0, w1, cyc, stalls, vcnt;
        vecs[0]  = '{1'b1, 9'd9, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b1, 9'd9, 4'b0101, 32'h0000_0000, 32'h0};
        vecs[2]  = '{1'b0, 9'd9, 4'b0000, 32'h0,         32'hFF00_FF00};
        vecs[3]  = '{1'b1, 9'd1, 4'b1111, 32'h1111_1111, 32'h0};
        vecs[4]  = '{1'b1, 9'd2, 4'b1111, 32'h2222_2222, 32'h0};
        vecs[5]  = '{1'b1, 9'd3, 4'b1111, 32'h3333_3333, 32'h0};
        vecs[6]  = '{1'b1, 9'd4, 4'b1111, 32'h4444_4444, 32'h0};
        vecs[7]  = '{1'b0, 9'd1, 4'b0000, 32'h0,         32'h1111_1111};
        vecs[8]  = '{1'b0, 9'd2, 4'b0000, 32'h0,         32'h2222_2222};
        vecs[9]  = '{1'b0, 9'd3, 4'b0000, 32'h0,         32'h3333_3333};
        vecs[10] = '{1'b0, 9'd4, 4'b0000, 32'h0,         32'h4444_4444};
        vecs[11] = '{1'b1, 9'd9, 4'b0000, 32'hA5A5_A5A5, 32'h0};
        vecs[12] = '{1'b0, 9'd9, 4'b0000, 32'h0,         32'hFF00_FF00};
        vecs[13] = '{1'b1, 9'd7, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[14] = '{1'b0, 9'd7, 4'b0000, 32'h0,         32'hCAFE_F00D};
        vecs[15] = '{1'b1, 9'd7, 4'b1000, 32'h1234_5678, 32'h0};
        vecs[16] = '{1'b0, 9'd7, 4'b0000, 32'h0,         32'h12FE_F00D};

        rst0      = 1'b1;
        rsp_ready = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        idle();
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        check("rst_csb0", csb0, 1);
        check("rst_web0", web0, 1);
        check("rst_wmask0", wmask0, 0);
        check("rst_addr0", addr0, 0);
        check("rst_din0", din0, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_init_done", init_done, 0);
        @(posedge clk0);
        #1;
        rst0 = 1'b0;
        wait_init(cyc);
        check("init_latency", cyc, INIT_CYC);

        // Write then read addr 5; response must appear exactly two cycles after accept.
        issue(1'b1, 9'd5, 4'b1111, 32'hDEAD_BEEF, 32'h0, w);
        issue(1'b0, 9'd5, 4'b0000, 32'h0, 32'hDEAD_BEEF, w);
        idle();
        @(posedge clk0);
        #1;
        check("t1_valid_early", rsp_valid, 0);
        @(posedge clk0);
        #1;
        check("t1_valid_t2", rsp_valid, 1);
        check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
        drain();

        // Table: masks, in-order reads, no-op write, read-after-write.
        rsp_ready = 1'b1;
        vcnt = 0;
        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].mask, vecs[i].wdata, vecs[i].exp, w);
            vcnt++;
        end
        check("table_len", vcnt, 17);
        drain();

        // Two reads from an empty pipeline are accepted on consecutive edges.
        issue(1'b0, 9'd1, 4'b0, 32'h0, 32'h1111_1111, w0);
        issue(1'b0, 9'd2, 4'b0, 32'h0, 32'h2222_2222, w1);
        check("t3_b2b_waits", w0 + w1, 0);
        drain();

        // Back-pressure: credits run out at RSP_DEPTH, then recover without loss.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'd1;
        @(negedge clk0);
        check("t4_ready0", req_ready, 1);
        @(posedge clk0);
        #1;
        exp_q.push_back(32'h1111_1111);
        req_addr = 9'd2;
        @(negedge clk0);
        check("t4_ready1", req_ready, 1);
        @(posedge clk0);
        #1;
        exp_q.push_back(32'h2222_2222);
        req_addr = 9'd3;
        stalls = 0;
        repeat (4) begin
            @(negedge clk0);
            if (req_ready) stalls++;
            @(posedge clk0);
            #1;
        end
        check("t4_ready_low", stalls, 0);
        check("t4_hold_valid", rsp_valid, 1);
        check("t4_hold_data", rsp_rdata, 32'h1111_1111);
        rsp_ready = 1'b1;
        issue(1'b0, 9'd3, 4'b0, 32'h0, 32'h3333_3333, w);
        drain();

        // Reset with two reads in flight.
        issue(1'b0, 9'd2, 4'b0, 32'h0, 32'h2222_2222, w);
        issue(1'b0, 9'd4, 4'b0, 32'h0, 32'h4444_4444, w);
        rst0 = 1'b1;
        idle();
        exp_q.delete();
        @(posedge clk0);
        #1;
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_csb0", csb0, 1);
        check("t5_req_ready", req_ready, 0);
        rst0 = 1'b0;
        stalls = 0;
        repeat (6) begin
            @(posedge clk0);
            #1;
            if (rsp_valid) stalls++;
        end
        check("t5_no_rsp", stalls, 0);
        wait_init(cyc);
`ifdef SRAM_CTRL_SCRUB_EN
        issue(1'b0, 9'd4, 4'b0, 32'h0, 32'h0, w);
        issue(1'b0, 9'd511, 4'b0, 32'h0, 32'h0, w);
`else
        issue(1'b0, 9'd4, 4'b0, 32'h0, 32'h4444_4444, w);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
